restoring_divider: RTL and testbench

- Sequential unsigned integer divider producing quotient and remainder.
- Built around a ripple-borrow trial subtractor and consumes its difference/borrow-out every iteration, one quotient bit per clock.
- Sits directly downstream of the full_subtractor datapath. It is the first clocked arithmetic unit in the codebase; later stages receive its registered results via a START/DONE handshake.

---
 rtl/divider_pkg.sv | 13 +
 rtl/trial_subtractor.sv | 24 ++
 rtl/restoring_divider.sv | 139 +++++++++++++
 tb/tb_restoring_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH  = 8;
    localparam int ITERATIONS = DIV_WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational ripple-borrow subtractor: diff = a - b - bin, bout = borrow out of the MSB.
module trial_subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Ripple the borrow from LSB to MSB, one full-subtractor cell per bit.
    always_comb begin
        logic borrow;
        borrow = bin;
        diff   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        bout = borrow;
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIVIDER_ZERO_CHECK_EN: a zero divisor completes in one cycle
// and raises DIV_BY_ZERO; without it a zero divisor runs the normal iteration path.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    state_e           state_q;
    logic [WIDTH:0]   p_q;      // partial remainder, one bit wider than the divisor
    logic [WIDTH-1:0] dvd_q;    // dividend shifts out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic             trial_bout;
    logic             qbit;
    logic [WIDTH:0]   p_next;
    logic             last_iter;

    // Bring down the next dividend bit and pick restore vs. keep.
    always_comb begin
        p_shift   = {p_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        qbit      = ~trial_bout;
        p_next    = trial_bout ? p_shift : trial;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    trial_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_trial_subtractor (
        .a    (p_shift),
        .b    ({1'b0, dvs_q}),
        .bin  (1'b0),
        .diff (trial),
        .bout (trial_bout)
    );

`ifdef DIVIDER_ZERO_CHECK_EN
    logic dbz_q;
`endif

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            p_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (START) begin
                        dvd_q <= DIVIDEND;
                        dvs_q <= DIVISOR;
                        p_q   <= '0;
                        cnt_q <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
                        if (DIVISOR == '0) begin
                            quo_q   <= '1;
                            rem_q   <= DIVIDEND;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    p_q   <= p_next;
                    dvd_q <= {dvd_q[WIDTH-2:0], qbit};
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quo_q   <= {dvd_q[WIDTH-2:0], qbit};
                        rem_q   <= p_next[WIDTH-1:0];
`ifdef DIVIDER_ZERO_CHECK_EN
                        dbz_q   <= 1'b0;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign QUOTIENT  = quo_q;
    assign REMAINDER = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    assign DIV_BY_ZERO = dbz_q;
`else
    assign DIV_BY_ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider; expected results are queued at START and
// compared when DONE pulses.
module tb_restoring_divider;

    localparam int W = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] DIVIDEND = '0;
    logic [W-1:0] DIVISOR = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] QUOTIENT;
    logic [W-1:0] REMAINDER;
    logic         DIV_BY_ZERO;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_start  = 0;
    int   n_done   = 0;
    logic prev_done = 1'b0;

    restoring_divider dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        if (dvs == 0) begin
            e.quo = '1;
            e.rem = dvd;
            e.dbz = ZC;
        end else begin
            e.quo = dvd / dvs;
            e.rem = dvd % dvs;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: compare every DONE pulse against the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE) begin
            exp_t e;
            n_done++;
            if (prev_done) check("done_single_cycle", 32'(prev_done), 0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("quotient", 32'(QUOTIENT), 32'(e.quo));
                check("remainder", 32'(REMAINDER), 32'(e.rem));
                check("div_by_zero", 32'(DIV_BY_ZERO), 32'(e.dbz));
            end
        end
        prev_done = DONE;
    end

    // Drive one START pulse (accepted at the next edge) and queue its expected result.
    task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        @(posedge CLK);
        #1;
        START    = 1'b1;
        DIVIDEND = dvd;
        DIVISOR  = dvs;
        exp_q.push_back(model(dvd, dvs));
        n_start++;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Wait on negedges until DONE, bounded; cycles counts negedges after the START edge.
    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (!DONE && cycles < max_cycles);
        if (!DONE) check("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_quotient", 32'(QUOTIENT), 0);
        check("rst_remainder", 32'(REMAINDER), 0);
        check("rst_dbz", 32'(DIV_BY_ZERO), 0);

        // 200/7 with cycle-exact BUSY/DONE timing; outputs must hold during CALC.
        start_op(8'd200, 8'd7);
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            check("t1_busy", 32'(BUSY), 1);
            check("t1_done_early", 32'(DONE), 0);
            check("t1_quo_held", 32'(QUOTIENT), 0);
        end
        @(negedge CLK);
        check("t1_busy_end", 32'(BUSY), 0);
        check("t1_done", 32'(DONE), 1);
        repeat (2) @(negedge CLK);

        // 255/1 then 5/9 back to back, second START during the DONE cycle.
        start_op(8'd255, 8'd1);
        wait_done(20, lat);
        START    = 1'b1;
        DIVIDEND = 8'd5;
        DIVISOR  = 8'd9;
        exp_q.push_back(model(8'd5, 8'd9));
        n_start++;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check("b2b_busy", 32'(BUSY), 1);
        check("b2b_held_quo", 32'(QUOTIENT), 255);
        wait_done(20, lat);
        check("b2b_latency", 32'(lat), W);
        repeat (2) @(negedge CLK);

        // Zero divisor.
        start_op(8'd77, 8'd0);
        wait_done(20, lat);
        check("zero_latency", 32'(lat), ZC ? 1 : W + 1);
        repeat (2) @(negedge CLK);

        // Non-zero completion after zero divisor; START during CALC ignored.
        start_op(8'd100, 8'd3);
        @(posedge CLK);
        #1;
        START    = 1'b1;
        DIVIDEND = 8'd9;
        DIVISOR  = 8'd2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(20, lat);
        check("ignore_latency", 32'(lat), W - 1);
        repeat (3) @(negedge CLK);
        check("ignore_no_extra", 32'(exp_q.size()), 0);

        // Reset mid-calculation discards the operation and clears outputs.
        start_op(8'd100, 8'd3);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        void'(exp_q.pop_back());
        n_start--;
        @(negedge CLK);
        check("midrst_busy", 32'(BUSY), 0);
        check("midrst_done", 32'(DONE), 0);
        check("midrst_quotient", 32'(QUOTIENT), 0);
        check("midrst_remainder", 32'(REMAINDER), 0);
        check("midrst_dbz", 32'(DIV_BY_ZERO), 0);
        repeat (W + 2) @(negedge CLK);
        check("midrst_no_done", 32'(n_done), 32'(n_start));
        start_op(8'd17, 8'd5);
        wait_done(20, lat);

        // Corner pairs followed by a random sample of non-zero divisors.
        begin
            logic [W-1:0] cd[6];
            logic [W-1:0] cv[6];
            cd = '{8'd0, 8'd255, 8'd254, 8'd1, 8'd128, 8'd255};
            cv = '{8'd1, 8'd255, 8'd255, 8'd255, 8'd2, 8'd16};
            for (int i = 0; i < 6; i++) begin
                start_op(cd[i], cv[i]);
                wait_done(20, lat);
            end
        end
        for (int i = 0; i < 600; i++) begin
            dvd = 8'($urandom_range(0, 255));
            dvs = 8'($urandom_range(1, 255));
            start_op(dvd, dvs);
            wait_done(20, lat);
        end

        repeat (4) @(negedge CLK);
        check("done_count", 32'(n_done), 32'(n_start));
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
